operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DATA_W, 32, operand and register width in bits.
REQ-002 Parameter: REG_N, 32, number of architectural registers, indexed by 5 bits.
REQ-003 The block SHALL provide these ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  upstream holds a decoded instruction.
- issue_ready  output  1  block accepts the instruction this cycle.
- issue_rs  input  5  source register A index.
- issue_rt  input  5  source register B index.
- issue_rd  input  5  destination register index.
- issue_op  input  6  ALU operation code, passed through.
- issue_imm  input  DATA_W  immediate operand.
- issue_use_imm  input  1  regB is taken from issue_imm instead of register rt.
- ex_valid  output  1  regA/regB/aluOp/ex_rd hold a valid operation.
- ex_ready  input  1  downstream ALU stage consumes the operation this cycle.
- regA  output  DATA_W  operand A, registered.
- regB  output  DATA_W  operand B, registered.
- aluOp  output  6  operation code, registered.
- ex_rd  output  5  destination index, registered.
- wb_en  input  1  write-back strobe.
- wb_rd  input  5  write-back register index.
- wb_data  input  DATA_W  write-back value.
- flush  input  1  discard the in-flight operation and all pending marks.

Function
REQ-004 The block SHALL hold a REG_N x DATA_W register file; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-005 When wb_en=1 and wb_rd!=0, the block SHALL write wb_data into register wb_rd on the clock edge.
REQ-006 The block SHALL keep one pending bit per register: set on an accepted issue with rd!=0, cleared on a write-back to that index; if both happen in the same cycle, set wins.
REQ-007 issue_ready SHALL be 1 only when all of the following hold; it is combinational:
- (ex_valid=0 or ex_ready=1), and flush=0;
- rs is not pending;
- rt is not pending, or issue_use_imm=1;
- rd is not pending.
A pending index SHALL count as not pending in the cycle that wb_en=1 and wb_rd matches it.
REQ-008 An instruction SHALL be accepted when issue_valid=1 and issue_ready=1; on the next edge ex_valid SHALL be 1 and regA/regB/aluOp/ex_rd SHALL be loaded (one-cycle latency).
REQ-009 Bypass: a source index that equals a nonzero wb_rd with wb_en=1 in the accept cycle SHALL take wb_data instead of the register-file value.
REQ-010 With issue_use_imm=1, regB SHALL equal issue_imm unmodified.
REQ-011 While ex_valid=1 and ex_ready=0, all ex_* outputs, regA, regB and aluOp SHALL stay stable.
REQ-012 When ex_valid=1, ex_ready=1 and no new accept occurs, ex_valid SHALL go to 0 on the next edge; the data outputs SHALL retain their last values.
REQ-013 Back-to-back: consume and accept in the same cycle SHALL load the new operation, with no bubble.
REQ-014 flush=1 SHALL, on the next edge:
- clear ex_valid;
- clear all pending bits, including bits that a write-back in the same cycle would have cleared;
- leave register-file contents unchanged, while still performing a write-back in the same cycle.

Reset
REQ-015 reset=1 SHALL, on the next edge:
- clear ex_valid, regA, regB, aluOp, ex_rd, all pending bits and all registers to 0;
- take priority over flush, issue and write-back.
REQ-016 A reset asserted while an operation is stalled SHALL discard that operation, and ex_valid SHALL read 0 in the following cycle.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then issue rs=0, rt=0, op=6'b000000 with ex_ready=1 -> next cycle ex_valid=1, regA=0, regB=0, aluOp=0.
- Write back r5=32'h0000_00AA, then issue rs=5 with use_imm=1 and imm=32'h10 -> regA=32'hAA, regB=32'h10.
- Issue rd=3, then issue rs=3 -> issue_ready=0 until wb_en=1 with wb_rd=3 and wb_data=32'h7; in that cycle issue_ready=1 and regA=32'h7 via bypass.
- ex_ready=0 for 4 cycles with ex_valid=1 -> outputs constant and issue_ready=0; ex_ready=1 with a new issue pending -> new operands in the next cycle, no bubble.
- Issue rd=9 then flush=1 -> ex_valid=0 next cycle, r9 not pending, and an issue with rs=9 is accepted immediately.
- wb_en=1 with wb_rd=0 and wb_data=32'hFFFF_FFFF -> a later issue rs=0 gives regA=0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: register file read with write-back bypass, scoreboard hazard check, registered ALU operands.
// Latency: one cycle from accepted issue to ex_valid with regA/regB/aluOp/ex_rd loaded.
// Backpressure: issue_ready drops while the output stage is stalled, on flush, or when a source/dest register is pending.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   issue_*              decoded instruction in (valid/ready handshake)
//   ex_*, regA/regB/aluOp registered operation out (valid/ready handshake)
//   wb_en/wb_rd/wb_data  register write-back, also bypassed into a same-cycle issue
//   flush                drop the in-flight operation and all pending marks
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        issue_rs,
  input  logic [4:0]        issue_rt,
  input  logic [4:0]        issue_rd,
  input  logic [5:0]        issue_op,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic              issue_use_imm,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  output logic [5:0]        aluOp,
  output logic [4:0]        ex_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  logic [DATA_W-1:0] rf_q [REG_N];
  logic [REG_N-1:0]  pend_q, pend_d;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] regA_q, regA_d;
  logic [DATA_W-1:0] regB_q, regB_d;
  logic [5:0]        aluOp_q, aluOp_d;
  logic [4:0]        ex_rd_q, ex_rd_d;

  logic              wb_hit;
  logic              rs_busy, rt_busy, rd_busy;
  logic              out_free;
  logic              accept;
  logic [DATA_W-1:0] opa, opb;

  // A write-back to r0 is architecturally a no-op.
  assign wb_hit = wb_en && (wb_rd != 5'd0);

  // A pending register whose write-back lands this cycle is already resolved,
  // since the value is forwarded from wb_data.
  assign rs_busy = pend_q[issue_rs] && !(wb_en && (wb_rd == issue_rs));
  assign rt_busy = pend_q[issue_rt] && !(wb_en && (wb_rd == issue_rt));
  assign rd_busy = pend_q[issue_rd] && !(wb_en && (wb_rd == issue_rd));

  assign out_free    = !ex_valid_q || ex_ready;
  assign issue_ready = out_free && !flush && !rs_busy &&
                       (issue_use_imm || !rt_busy) && !rd_busy;
  assign accept      = issue_valid && issue_ready;

  // Operand read with write-back bypass; r0 is forced to zero regardless of storage.
  always_comb begin
    opa = '0;
    opb = '0;
    if (issue_rs != 5'd0) begin
      opa = (wb_hit && (wb_rd == issue_rs)) ? wb_data : rf_q[issue_rs];
    end
    if (issue_rt != 5'd0) begin
      opb = (wb_hit && (wb_rd == issue_rt)) ? wb_data : rf_q[issue_rt];
    end
    if (issue_use_imm) begin
      opb = issue_imm;
    end
  end

  // Pending scoreboard: a new destination mark overrides a same-cycle clear;
  // flush wipes everything.
  always_comb begin
    pend_d = pend_q;
    if (wb_en) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (accept && (issue_rd != 5'd0)) begin
      pend_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  // Output stage: load on accept, drain on consume, hold otherwise.
  always_comb begin
    ex_valid_d = ex_valid_q;
    regA_d     = regA_q;
    regB_d     = regB_q;
    aluOp_d    = aluOp_q;
    ex_rd_d    = ex_rd_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      regA_d     = opa;
      regB_d     = opb;
      aluOp_d    = issue_op;
      ex_rd_d    = issue_rd;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (flush) begin
      ex_valid_d = 1'b0;
    end
  end

  // Register file: write-back still lands during a flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_hit) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q     <= '0;
      ex_valid_q <= 1'b0;
      regA_q     <= '0;
      regB_q     <= '0;
      aluOp_q    <= '0;
      ex_rd_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      ex_valid_q <= ex_valid_d;
      regA_q     <= regA_d;
      regB_q     <= regB_d;
      aluOp_q    <= aluOp_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign regA     = regA_q;
  assign regB     = regB_q;
  assign aluOp    = aluOp_q;
  assign ex_rd    = ex_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural reference model.
module tb_operand_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic [5:0]  issue_op;
  logic [31:0] issue_imm;
  logic        issue_use_imm;
  logic        ex_valid, ex_ready;
  logic [31:0] regA, regB;
  logic [5:0]  aluOp;
  logic [4:0]  ex_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;

  always #5 clock = ~clock;

  operand_fetch #(.DATA_W(32), .REG_N(32)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_op(issue_op), .issue_imm(issue_imm), .issue_use_imm(issue_use_imm),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .regA(regA), .regB(regB), .aluOp(aluOp), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  typedef struct {
    logic        rst, iv;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        ui, exr, wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl;
    logic        chk_rdy, e_rdy;   // check issue_ready in this cycle
    logic        chk_ex, e_exv;    // check outputs after the edge
    logic [31:0] e_a, e_b;
    logic [5:0]  e_op;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: architectural registers, in-flight destinations,
  // and the operation currently presented downstream.
  logic [31:0] rf_m [32];
  logic        pend_m [32];
  logic        exv_m;
  logic [31:0] a_m, b_m;
  logic [5:0]  op_m;
  logic [4:0]  rd_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, iv, input logic [4:0] rs, rt, rd,
                              input logic [5:0] op, input logic [31:0] imm,
                              input logic ui, exr, wbe, input logic [4:0] wbrd,
                              input logic [31:0] wbd, input logic fl,
                              input logic cr, er, ce, ee,
                              input logic [31:0] ea, eb, input logic [5:0] eo);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.op = op;
    v.imm = imm; v.ui = ui; v.exr = exr; v.wbe = wbe; v.wbrd = wbrd;
    v.wbd = wbd; v.fl = fl; v.chk_rdy = cr; v.e_rdy = er; v.chk_ex = ce;
    v.e_exv = ee; v.e_a = ea; v.e_b = eb; v.e_op = eo;
    return v;
  endfunction

  // A register is a hazard if it is still awaited, unless its value arrives right now.
  function automatic logic m_busy(input logic [4:0] i, input vec_t v);
    return pend_m[i] && !(v.wbe && v.wbrd == i);
  endfunction

  function automatic logic m_ready(input vec_t v);
    return (!exv_m || v.exr) && !v.fl && !m_busy(v.rs, v) &&
           (v.ui || !m_busy(v.rt, v)) && !m_busy(v.rd, v);
  endfunction

  function automatic logic [31:0] m_src(input logic [4:0] i, input vec_t v);
    if (i == 5'd0) return 32'h0;
    if (v.wbe && v.wbrd == i) return v.wbd;
    return rf_m[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      rf_m[i] = 32'h0;
      pend_m[i] = 1'b0;
    end
    exv_m = 1'b0; a_m = 32'h0; b_m = 32'h0; op_m = 6'h0; rd_m = 5'h0;
  endtask

  task automatic m_step(input vec_t v, input logic rdy);
    logic acc;
    if (v.rst) begin
      m_reset();
      return;
    end
    acc = v.iv && rdy;
    if (acc) begin
      exv_m = 1'b1;
      a_m   = m_src(v.rs, v);
      b_m   = v.ui ? v.imm : m_src(v.rt, v);
      op_m  = v.op;
      rd_m  = v.rd;
    end else if (v.exr) begin
      exv_m = 1'b0;
    end
    if (v.fl) exv_m = 1'b0;
    if (v.wbe && v.wbrd != 5'd0) rf_m[v.wbrd] = v.wbd;
    if (v.fl) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    end else begin
      if (v.wbe) pend_m[v.wbrd] = 1'b0;
      if (acc && v.rd != 5'd0) pend_m[v.rd] = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic mr;
    reset = v.rst; issue_valid = v.iv; issue_rs = v.rs; issue_rt = v.rt;
    issue_rd = v.rd; issue_op = v.op; issue_imm = v.imm; issue_use_imm = v.ui;
    ex_ready = v.exr; wb_en = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd; flush = v.fl;
    #1;
    mr = 1'b0;
    if (!v.rst) begin
      mr = m_ready(v);
      chk("ready_model", 32'(issue_ready), 32'(mr));
    end
    if (v.chk_rdy) chk("ready_vec", 32'(issue_ready), 32'(v.e_rdy));
    m_step(v, mr);
    @(posedge clock);
    #1;
    chk("ex_valid_model", 32'(ex_valid), 32'(exv_m));
    chk("regA_model", regA, a_m);
    chk("regB_model", regB, b_m);
    chk("aluOp_model", 32'(aluOp), 32'(op_m));
    chk("ex_rd_model", 32'(ex_rd), 32'(rd_m));
    if (v.chk_ex) begin
      chk("ex_valid_vec", 32'(ex_valid), 32'(v.e_exv));
      chk("regA_vec", regA, v.e_a);
      chk("regB_vec", regB, v.e_b);
      chk("aluOp_vec", 32'(aluOp), 32'(v.e_op));
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    m_reset();

    //            rst iv rs rt rd op imm        ui exr wbe wbrd wbd           fl  cr er ce ee ea          eb        eo
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,     0, 0, 0, 0,  32'h0,         0,  0, 0, 1, 0, 32'h0,     32'h0,    0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0,  32'h0,         0,  1, 1, 1, 1, 32'h0,     32'h0,    0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     0, 1, 1, 5,  32'hAA,        0,  0, 0, 1, 0, 32'h0,     32'h0,    0));
    tbl.push_back(mk(0, 1, 5, 0, 0, 1, 32'h10,    1, 1, 0, 0,  32'h0,         0,  1, 1, 1, 1, 32'hAA,    32'h10,   1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 2, 32'h0,     0, 1, 0, 0,  32'h0,         0,  1, 1, 1, 1, 32'h0,     32'h0,    2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 32'h0,     0, 1, 0, 0,  32'h0,         0,  1, 0, 1, 0, 32'h0,     32'h0,    2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 32'h0,     0, 1, 0, 0,  32'h0,         0,  1, 0, 1, 0, 32'h0,     32'h0,    2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 32'h0,     0, 1, 1, 3,  32'h7,         0,  1, 1, 1, 1, 32'h7,     32'h0,    3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     0, 1, 1, 0,  32'hFFFF_FFFF, 0,  0, 0, 1, 0, 32'h7,     32'h0,    3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4, 32'h0,     0, 1, 0, 0,  32'h0,         0,  1, 1, 1, 1, 32'h0,     32'h0,    4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 5, 32'h0,     0, 1, 1, 0,  32'hFFFF_FFFF, 0,  1, 1, 1, 1, 32'h0,     32'h0,    5));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Stall for four cycles with a new issue waiting, then release: no bubble.
    run_vec(mk(0, 1, 5, 0, 0, 6, 32'h0, 0, 1, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'hAA, 32'h0, 6));
    for (int i = 0; i < 4; i++)
      run_vec(mk(0, 1, 0, 0, 0, 7, 32'h55, 1, 0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'hAA, 32'h0, 6));
    run_vec(mk(0, 1, 0, 0, 0, 7, 32'h55, 1, 1, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h0, 32'h55, 7));

    // Flush with r9 pending; a write-back to r12 in the flush cycle still lands.
    run_vec(mk(0, 1, 0, 0, 9, 8, 32'h0, 0, 1, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h0, 32'h0, 8));
    run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 12, 32'h99, 1, 1, 0, 1, 0, 32'h0, 32'h0, 8));
    run_vec(mk(0, 1, 9, 12, 4, 9, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h0, 32'h99, 9));

    // Reset while that operation is stalled and r4 is pending.
    run_vec(mk(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0));
    run_vec(mk(0, 1, 4, 12, 0, 11, 32'h0, 0, 1, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h0, 32'h0, 11));
    run_vec(mk(0, 1, 5, 0, 0, 12, 32'h0, 0, 1, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h0, 32'h0, 12));

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      v = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      v.rst  = ($urandom_range(0, 199) == 0);
      v.fl   = ($urandom_range(0, 39) == 0);
      v.iv   = ($urandom_range(0, 3) != 0);
      v.rs   = 5'($urandom_range(0, 7));
      v.rt   = 5'($urandom_range(0, 7));
      v.rd   = 5'($urandom_range(0, 7));
      v.op   = 6'($urandom_range(0, 63));
      v.imm  = $urandom;
      v.ui   = 1'($urandom_range(0, 1));
      v.exr  = ($urandom_range(0, 9) < 7);
      v.wbe  = 1'($urandom_range(0, 1));
      v.wbrd = ($urandom_range(0, 1) == 1) ? rd_m : 5'($urandom_range(0, 7));
      v.wbd  = $urandom;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
